grf_multiport: RTL and testbench
================================

Name: grf_multiport

Overview:
Parametrised general register file, successor to the single-write, two-read GRF.
- Configurable data width, depth and number of read ports.
- Two write ports with write-through bypass.
- Per-register pending-write scoreboard for hazard detection.
- Multi-cycle sequential clear engine, replacing the single-cycle bulk reset.
- Sits in the ID stage: reads in ID, issue marks in ID, writebacks from late pipeline stages.

Parameters:
WIDTH, 32, data width of each register
ADDR_W, 5, address width; DEPTH = 2**ADDR_W
NREAD, 2, number of read ports
PEND_W, 2, width of each per-register pending counter

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset; starts the clear sequence
clear_req  input  1  requests a full clear while ready
ready  output  1  1 = file usable; 0 = clearing
rd_addr  input  NREAD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
rd_data  output  NREAD*WIDTH  read data, same packing as rd_addr
rd_pending  output  NREAD  1 = the addressed register has an outstanding write
we0  input  1  write enable, port 0 (older stage)
wa0  input  ADDR_W  write address, port 0
wd0  input  WIDTH  write data, port 0
we1  input  1  write enable, port 1 (younger stage, higher priority)
wa1  input  ADDR_W  write address, port 1
wd1  input  WIDTH  write data, port 1
issue_en  input  1  marks a future write to issue_addr
issue_addr  input  ADDR_W  destination register being issued
issue_ok  output  1  pending counter of issue_addr is not saturated

Behaviour:
State machine: CLEAR, READY.
- reset=1 at an edge: state <= CLEAR, idx <= 0. All writes, issues and clear_req are ignored.
- CLEAR, reset=0, each edge: entry[idx] <= 0, pend[idx] <= 0, idx <= idx+1.
- After clearing entry DEPTH-1: state <= READY.
- ready=1 exactly DEPTH edges after the last edge sampled with reset=1.
- reset asserted mid-clear: restart at idx 0.
- READY with clear_req=1: enter CLEAR at idx 0. Any write or issue in that same cycle is dropped.
- In CLEAR: ready=0, rd_data all 0, rd_pending all 0, issue_ok=0, writes and issues ignored.

Register 0:
- Reads always return 0.
- Writes to register 0 are discarded.
- Issue to register 0 is a no-op: issue_ok=1, rd_pending=0.

Writes (READY state):
- An enabled port with address != 0 updates the entry at the clock edge.
- Same address on both ports: port 1 value is stored.

Reads (READY state):
- Combinational, zero latency.
- Bypass priority: (we1 && wa1==addr && addr!=0) gives wd1; else (we0 && wa0==addr && addr!=0) gives wd0; else the stored entry.

Scoreboard (READY state):
- pend[r] is unsigned PEND_W bits.
- Each edge: pend[r] += (issue_en && issue_addr==r && issue_ok) - (we0 && wa0==r) - (we1 && wa1==r).
- Decrement saturates at 0; a write to a non-pending register is legal.
- issue_ok = (pend[issue_addr] != 2**PEND_W-1). An issue with issue_ok=0 does not change the counter.
- Increment and decrement to the same register in the same cycle net to 0 change.
- rd_pending[k] = (pend[addr_k] after subtracting this cycle's writes to addr_k) != 0, i.e. a write landing this cycle is visible as resolved.

Test Plan:
- Clear timing: reset high 3 cycles, then low -> ready=0 for exactly 32 edges, ready=1 after the 32nd; every register reads 0.
- Bypass and priority: in the same cycle we0 wa0=5 wd0=0x11111111 and we1 wa1=5 wd1=0x22222222, rd_addr port 0=5 -> rd_data port 0 = 0x22222222 that cycle; 0x22222222 on the next cycle with no writes.
- Register 0: we1 wa1=0 wd1=0xDEADBEEF, read 0 on both ports -> 0 both that cycle and the next; issue to 0 -> issue_ok=1, rd_pending=0.
- Scoreboard saturation: issue reg 7 three times -> issue_ok=0. A fourth issue leaves the count at 3. Three we0 writes to 7 -> rd_pending=0 during the third write cycle.
- Simultaneous issue and write: reg 9 pend=1, issue_en to 9 plus we1 to 9 in the same cycle -> pend stays 1, rd_pending for reg 9 = 1.
- Clear interruption: clear_req while reg 3=0xABCD and pend[3]=2, then reset pulsed at idx 10 -> ready returns 32 edges after the reset deasserts; reg 3 reads 0, pend[3]=0; writes issued during CLEAR have no effect.

Source files
------------

// File: rtl/grf_multiport_if.sv
// Register-file access bundle: read ports, two write ports and the issue/scoreboard port.
interface grf_multiport_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2
);
  logic [NREAD*ADDR_W-1:0] rd_addr;
  logic [NREAD*WIDTH-1:0]  rd_data;
  logic [NREAD-1:0]        rd_pending;
  logic                    we0;
  logic [ADDR_W-1:0]       wa0;
  logic [WIDTH-1:0]        wd0;
  logic                    we1;
  logic [ADDR_W-1:0]       wa1;
  logic [WIDTH-1:0]        wd1;
  logic                    issue_en;
  logic [ADDR_W-1:0]       issue_addr;
  logic                    issue_ok;

  modport master (
    output rd_addr, we0, wa0, wd0, we1, wa1, wd1, issue_en, issue_addr,
    input  rd_data, rd_pending, issue_ok
  );

  modport slave (
    input  rd_addr, we0, wa0, wd0, we1, wa1, wd1, issue_en, issue_addr,
    output rd_data, rd_pending, issue_ok
  );
endinterface

// File: rtl/grf_multiport.sv
// Multi-read, dual-write general register file with write-through bypass,
// per-register pending-write scoreboard and a sequential clear engine.
module grf_multiport #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2,
  parameter int PEND_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear_req,
  output logic            ready,
  grf_multiport_if.slave  bus
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] idx, idx_n;

  logic [WIDTH-1:0]  entry  [DEPTH];
  logic [PEND_W-1:0] pend   [DEPTH];
  logic [PEND_W-1:0] pend_n [DEPTH];

  logic issue_ok_int;
  logic update_en;

  // Saturating subtraction of 0..2 same-cycle writebacks from a counter value.
  function automatic logic [PEND_W-1:0] sat_sub(input logic [PEND_W:0] v,
                                                 input logic [1:0]      d);
    logic [PEND_W:0] dd;
    dd = (PEND_W+1)'(d);
    return (v < dd) ? '0 : PEND_W'(v - dd);
  endfunction

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_CLEAR;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      S_CLEAR: begin
        idx_n = idx + 1'b1;
        if (idx == '1) state_n = S_READY;
      end
      S_READY: begin
        if (clear_req) begin
          state_n = S_CLEAR;
          idx_n   = '0;
        end
      end
      default: begin
        state_n = S_CLEAR;
        idx_n   = '0;
      end
    endcase
  end

  assign ready        = (state == S_READY);
  assign update_en    = ready && !clear_req;
  assign issue_ok_int = ready && (pend[bus.issue_addr] != PEND_MAX);
  assign bus.issue_ok = issue_ok_int;

  // ---------------- storage ----------------
  // Port 1 assignment comes last so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == S_CLEAR) begin
        entry[idx] <= '0;
      end else if (update_en) begin
        if (bus.we0 && bus.wa0 != '0) entry[bus.wa0] <= bus.wd0;
        if (bus.we1 && bus.wa1 != '0) entry[bus.wa1] <= bus.wd1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  always_comb begin
    for (int unsigned r = 0; r < DEPTH; r++) begin
      logic            inc;
      logic [1:0]      hits;
      inc  = bus.issue_en && (bus.issue_addr == ADDR_W'(r)) && issue_ok_int;
      hits = 2'({1'b0, bus.we0 && (bus.wa0 == ADDR_W'(r))})
           + 2'({1'b0, bus.we1 && (bus.wa1 == ADDR_W'(r))});
      if (r == 0) pend_n[r] = '0;
      else        pend_n[r] = sat_sub({1'b0, pend[r]} + (PEND_W+1)'(inc), hits);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == S_CLEAR) begin
        pend[idx] <= '0;
      end else if (update_en) begin
        for (int unsigned r = 0; r < DEPTH; r++) pend[r] <= pend_n[r];
      end
    end
  end

  // ---------------- read ports ----------------
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [WIDTH-1:0]  data_k;
    logic              pend_k;
    logic [1:0]        hits_k;

    assign a      = bus.rd_addr[k*ADDR_W +: ADDR_W];
    assign hits_k = 2'({1'b0, bus.we0 && (bus.wa0 == a)})
                  + 2'({1'b0, bus.we1 && (bus.wa1 == a)});

    // A writeback landing this cycle already counts as resolved.
    always_comb begin
      data_k = '0;
      pend_k = 1'b0;
      if (ready && a != '0) begin
        if (bus.we1 && bus.wa1 == a)      data_k = bus.wd1;
        else if (bus.we0 && bus.wa0 == a) data_k = bus.wd0;
        else                              data_k = entry[a];
        pend_k = (sat_sub({1'b0, pend[a]}, hits_k) != '0);
      end
    end

    assign bus.rd_data[k*WIDTH +: WIDTH] = data_k;
    assign bus.rd_pending[k]             = pend_k;
  end

endmodule

// File: tb/tb_grf_multiport.sv
// Directed-vector bench for grf_multiport with hand-computed expectations.
module tb_grf_multiport;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;
  localparam int NREAD  = 2;

  logic clk = 1'b0;
  logic reset;
  logic clear_req;
  logic ready;

  int checks   = 0;
  int failures = 0;

  grf_multiport_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .NREAD(NREAD)) bus ();

  grf_multiport #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .NREAD(NREAD), .PEND_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear_req (clear_req),
    .ready     (ready),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we0 = 1'b0; bus.wa0 = '0; bus.wd0 = '0;
    bus.we1 = 1'b0; bus.wa1 = '0; bus.wd1 = '0;
    bus.issue_en = 1'b0; bus.issue_addr = '0;
    clear_req = 1'b0;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    bus.rd_addr[4:0] = a0;
    bus.rd_addr[9:5] = a1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    set_rd(5'd0, 5'd0);

    // Clear timing after power-up reset
    repeat (3) tick();
    reset = 1'b0;
    check("ready_in_reset", ready, 0);
    for (int i = 1; i <= 32; i++) begin
      tick();
      check($sformatf("clr_ready_e%0d", i), ready, (i == 32));
    end
    for (int a = 0; a < 32; a += 2) begin
      set_rd(5'(a), 5'(a + 1)); #1;
      check($sformatf("clr_rd0_%0d", a), bus.rd_data[31:0], 0);
      check($sformatf("clr_rd1_%0d", a + 1), bus.rd_data[63:32], 0);
    end

    // Bypass and port priority
    bus.we0 = 1'b1; bus.wa0 = 5'd5; bus.wd0 = 32'h11111111;
    bus.we1 = 1'b1; bus.wa1 = 5'd5; bus.wd1 = 32'h22222222;
    set_rd(5'd5, 5'd6); #1;
    check("byp_prio", bus.rd_data[31:0], 32'h22222222);
    tick(); idle(); #1;
    check("byp_stored", bus.rd_data[31:0], 32'h22222222);
    bus.we0 = 1'b1; bus.wa0 = 5'd6; bus.wd0 = 32'h00000066; #1;
    check("byp_port0", bus.rd_data[63:32], 32'h00000066);
    tick(); idle(); #1;
    check("stored_port0", bus.rd_data[63:32], 32'h00000066);

    // Register 0
    bus.we1 = 1'b1; bus.wa1 = 5'd0; bus.wd1 = 32'hDEADBEEF;
    set_rd(5'd0, 5'd0); #1;
    check("r0_byp_p0", bus.rd_data[31:0], 0);
    check("r0_byp_p1", bus.rd_data[63:32], 0);
    tick(); idle(); #1;
    check("r0_next_p0", bus.rd_data[31:0], 0);
    check("r0_next_p1", bus.rd_data[63:32], 0);
    bus.issue_en = 1'b1; bus.issue_addr = 5'd0; #1;
    check("r0_issue_ok", bus.issue_ok, 1);
    tick(); idle(); #1;
    check("r0_pending", bus.rd_pending[0], 0);

    // Scoreboard saturation on reg 7
    set_rd(5'd7, 5'd0);
    for (int i = 0; i < 3; i++) begin
      bus.issue_en = 1'b1; bus.issue_addr = 5'd7; #1;
      check($sformatf("sat_ok_%0d", i), bus.issue_ok, 1);
      tick();
    end
    idle(); bus.issue_addr = 5'd7; #1;
    check("sat_full", bus.issue_ok, 0);
    check("sat_pend", bus.rd_pending[0], 1);
    bus.issue_en = 1'b1; tick(); idle(); #1;
    for (int i = 0; i < 3; i++) begin
      bus.we0 = 1'b1; bus.wa0 = 5'd7; bus.wd0 = 32'h70 + i; #1;
      check($sformatf("sat_wr_pend_%0d", i), bus.rd_pending[0], (i < 2));
      tick();
    end
    idle(); #1;
    check("sat_drained", bus.rd_pending[0], 0);
    check("sat_data", bus.rd_data[31:0], 32'h72);
    bus.we1 = 1'b1; bus.wa1 = 5'd7; #1;
    check("extra_wr_pend", bus.rd_pending[0], 0);
    tick(); idle(); #1;
    bus.issue_addr = 5'd7; #1;
    check("extra_wr_ok", bus.issue_ok, 1);

    // Simultaneous issue and write on reg 9
    set_rd(5'd9, 5'd0);
    bus.issue_en = 1'b1; bus.issue_addr = 5'd9; tick(); idle(); #1;
    check("r9_pend1", bus.rd_pending[0], 1);
    bus.issue_en = 1'b1; bus.issue_addr = 5'd9;
    bus.we1 = 1'b1; bus.wa1 = 5'd9; bus.wd1 = 32'h99; #1;
    check("r9_same_cyc", bus.rd_pending[0], 0);
    tick(); idle(); #1;
    check("r9_still_pend", bus.rd_pending[0], 1);
    bus.we0 = 1'b1; bus.wa0 = 5'd9; tick(); idle(); #1;
    check("r9_resolved", bus.rd_pending[0], 0);

    // Clear interrupted by reset
    bus.we0 = 1'b1; bus.wa0 = 5'd3; bus.wd0 = 32'h0000ABCD; tick(); idle();
    for (int i = 0; i < 2; i++) begin
      bus.issue_en = 1'b1; bus.issue_addr = 5'd3; tick();
    end
    idle(); set_rd(5'd3, 5'd5); #1;
    check("r3_data", bus.rd_data[31:0], 32'h0000ABCD);
    check("r3_pend", bus.rd_pending[0], 1);
    clear_req = 1'b1;
    bus.we1 = 1'b1; bus.wa1 = 5'd3; bus.wd1 = 32'h33; tick(); idle(); #1;
    check("clrq_ready", ready, 0);
    check("clrq_rd5", bus.rd_data[63:32], 0);
    check("clrq_pend", bus.rd_pending[0], 0);
    bus.issue_en = 1'b1; bus.issue_addr = 5'd4; #1;
    check("clrq_issue_ok", bus.issue_ok, 0);
    bus.we1 = 1'b1; bus.wa1 = 5'd4; bus.wd1 = 32'h4444;
    repeat (10) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      tick();
      check($sformatf("rst_ready_e%0d", i), ready, (i == 32));
    end
    idle(); set_rd(5'd3, 5'd4); #1;
    check("post_r3", bus.rd_data[31:0], 0);
    check("post_r3_pend", bus.rd_pending[0], 0);
    check("post_r4", bus.rd_data[63:32], 0);
    check("post_r4_pend", bus.rd_pending[1], 0);
    set_rd(5'd5, 5'd7); #1;
    check("post_r5", bus.rd_data[31:0], 0);
    check("post_r7", bus.rd_data[63:32], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
